// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative round sequencer.
package aes_pkg;

  localparam int unsigned AES128_NR  = 10;
  localparam int unsigned AES_BLK    = 128;
  localparam int unsigned AES_MAX_NR = 14;
  localparam int unsigned AES_W_MAX  = 128 * (AES_MAX_NR + 1);

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_seq_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box = affine(x^254); the power chain yields 0 for 0, matching the AES definition.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = b;
    for (int unsigned i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round key r sits at w[128*(nr+1)-1-128*r -: 128]; w is zero-extended to AES_W_MAX.
  function automatic aes_block_t rk_slice(input logic [AES_W_MAX-1:0] w,
                                          input int unsigned nr, input int unsigned r);
    return aes_block_t'(w >> (128 * (nr - r)));
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / ciphertext-out handshake bundle between the upstream source and the round sequencer.
interface aes_round_sequencer_if
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR
) ();
  logic                    in_valid;
  logic                    in_ready;
  aes_block_t              in_block;
  logic [128*(NR+1)-1:0]   w;
  logic                    out_valid;
  logic                    out_ready;
  aes_block_t              out_block;
  logic                    busy;

  modport master (output in_valid, in_block, w, out_ready,
                  input  in_ready, out_valid, out_block, busy);
  modport slave  (input  in_valid, in_block, w, out_ready,
                  output in_ready, out_valid, out_block, busy);
endinterface

// File: rtl/aes_round_sequencer_round.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (skipped when is_final) -> AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t round_key,
  input  logic       is_final,
  output aes_block_t result
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i = state[127-8*i -: 8]; column-major, so row = i%4, column = i/4.
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    assign mc[4*c+0] = gf_mul(sr[4*c], 8'h02) ^ gf_mul(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ gf_mul(sr[4*c+1], 8'h02) ^ gf_mul(sr[4*c+2], 8'h03) ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul(sr[4*c+2], 8'h02) ^ gf_mul(sr[4*c+3], 8'h03);
    assign mc[4*c+3] = gf_mul(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul(sr[4*c+3], 8'h02);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign result[127-8*i -: 8] = (is_final ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer reusing one round datapath for all NR rounds.
// Define AES_KEY_LATCH_EN to capture w at accept; otherwise w must stay stable through FINAL.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR  = AES128_NR,
  parameter int unsigned BLK = AES_BLK
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus
);
  localparam int unsigned CW = $clog2(NR + 1);
  localparam int unsigned KW = 128 * (NR + 1);

  if (NR < 2)          $error("aes_round_sequencer: NR must be >= 2");
  if (NR > AES_MAX_NR) $error("aes_round_sequencer: NR exceeds AES_MAX_NR");
  if (BLK != AES_BLK)  $error("aes_round_sequencer: BLK must be 128");

  aes_seq_state_t st;
  logic [CW-1:0]  rnd;
  aes_block_t     state_q;
  aes_block_t     rk;
  aes_block_t     rk0;
  aes_block_t     rnd_out;
  logic [KW-1:0]  key_src;
  logic           accept;

  assign accept = bus.in_valid && bus.in_ready;

`ifdef AES_KEY_LATCH_EN
  logic [KW-1:0] key_q;
  always_ff @(posedge clk) begin
    if (accept) key_q <= bus.w;
  end
  assign key_src = key_q;
`else
  assign key_src = bus.w;
`endif

  // The initial whitening key comes straight from the port: the latch is only loaded at this edge.
  assign rk0 = rk_slice(AES_W_MAX'(bus.w), NR, 0);
  assign rk  = rk_slice(AES_W_MAX'(key_src), NR, 32'(rnd));

  aes_round u_round (
    .state     (state_q),
    .round_key (rk),
    .is_final  (st == FINAL),
    .result    (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      rnd           <= '0;
      state_q       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_block <= '0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (accept) begin
            state_q      <= bus.in_block ^ rk0;
            rnd          <= CW'(1);
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            st           <= ROUND;
          end
        end
        ROUND: begin
          state_q <= rnd_out;
          rnd     <= rnd + 1'b1;
          if (rnd == CW'(NR - 1)) st <= FINAL;
        end
        FINAL: begin
          state_q       <= rnd_out;
          bus.out_block <= rnd_out;
          bus.out_valid <= 1'b1;
          st            <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            rnd           <= '0;
            st            <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: FIPS-197 vectors, latency, back-pressure, ignore-while-busy, abort.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128 * (NR + 1);

  localparam aes_block_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_block_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam aes_block_t PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  aes_block_t exp_q [$];
  logic [KW-1:0] w_b;
  logic [KW-1:0] w_c;

  aes_round_sequencer_if #(.NR(NR)) bus ();

  aes_round_sequencer #(.NR(NR), .BLK(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] expand(input aes_block_t key);
    logic [31:0] wd [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [KW-1:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) wd[i] = 32'(key >> (96 - 32 * i));
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      wd[i] = wd[i-4] ^ t;
    end
    r = '0;
    for (int i = 0; i < 44; i++) r = (r << 32) | KW'(wd[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid with the given block until in_ready, then completes the accepting edge.
  task automatic send(input aes_block_t pt, input logic [KW-1:0] wv, output int acc);
    int k;
    bus.in_block = pt;
    bus.w        = wv;
    bus.in_valid = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      tick();
      k++;
    end
    check("accept_seen", bus.in_ready, 1'b1);
    acc = cyc;
    tick();
  endtask

  task automatic wait_out_valid(input string tag);
    int k;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    check(tag, bus.out_valid, 1'b1);
  endtask

  // Scoreboard: each ciphertext handshake pops the oldest expected block.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
      else check("ciphertext", bus.out_block, exp_q.pop_front());
    end
  end

  initial begin
    int a;
    int b;
    int k;
    logic [KW-1:0] rw;
    total = 0;
    bad   = 0;
    w_b   = expand(KEY_B);
    w_c   = expand(KEY_C);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_block = '0;
    bus.w        = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_block", bus.out_block, '0);
    check("rst_busy",      bus.busy,      1'b0);

    // App. B, then App. C.1 back-to-back; in_block changes during ROUND and must be ignored
    exp_q.push_back(CT_B);
    send(PT_B, w_b, a);
    bus.in_block = PT_C;
    exp_q.push_back(CT_C);
    check("busy_after_accept", bus.busy, 1'b1);
    wait_out_valid("b_out_valid");
    check("b_latency", 128'(cyc - a), 128'(11));
    bus.w = w_c;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      tick();
      k++;
    end
    check("c_in_ready", bus.in_ready, 1'b1);
    b = cyc;
    check("accept_spacing", 128'(b - a), 128'(12));
    tick();
    bus.in_valid = 1'b0;
    wait_out_valid("c_out_valid");
    check("c_latency", 128'(cyc - b), 128'(11));
    tick();

    // Back-pressure
    bus.out_ready = 1'b0;
    exp_q.push_back(CT_B);
    send(PT_B, w_b, a);
    bus.in_valid = 1'b0;
    wait_out_valid("bp_out_valid");
    for (int i = 0; i < 20; i++) begin
      check("bp_block",    bus.out_block, CT_B);
      check("bp_in_ready", bus.in_ready,  1'b0);
      check("bp_busy",     bus.busy,      1'b1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready",  bus.in_ready,  1'b1);
    check("bp_idle_busy",      bus.busy,      1'b0);
    check("bp_idle_out_valid", bus.out_valid, 1'b0);

    // Abort in cycle 5 of a block
    send(PT_C, w_c, a);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_out_block", bus.out_block, '0);
    check("abort_in_ready",  bus.in_ready,  1'b1);
    check("abort_busy",      bus.busy,      1'b0);
    exp_q.push_back(CT_B);
    send(PT_B, w_b, a);
    bus.in_valid = 1'b0;
    wait_out_valid("post_abort_valid");
    check("post_abort_latency", 128'(cyc - a), 128'(11));
    tick();

    // App. C.1 with w scrambled after accept when the key latch is built in
    exp_q.push_back(CT_C);
    send(PT_C, w_c, a);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
`ifdef AES_KEY_LATCH_EN
      rw = '0;
      for (int i = 0; i < 44; i++) rw = (rw << 32) | KW'($urandom);
      bus.w = rw;
`else
      rw = w_c;
      bus.w = rw;
`endif
      tick();
      k++;
    end
    check("latch_out_valid", bus.out_valid, 1'b1);
    tick();
    tick();

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
